// File: rtl/mul_iter_hs.sv
// mul_iter_hs: digit-serial W x W multiplier with valid/ready handshakes.
// Define MUL_ACC_EN to add a 2W addend port ic folded in during FIX.

module mul_iter_hs #(
    parameter int W = 256,
    parameter int D = 8,
    parameter int K = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [W-1:0]     ia,
    input  logic [W-1:0]     ib,
    input  logic             isgn,
    input  logic [K-1:0]     ikey,
    input  logic             ival,
    output logic             irdy,
    output logic [2*W-1:0]   o,
    output logic [K-1:0]     okey,
    output logic             oval,
`ifdef MUL_ACC_EN
    input  logic [2*W-1:0]   ic,
`endif
    input  logic             ordy
);

    localparam int ND = W / D;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;
    localparam int W2 = 2 * W;

    if (W < 2 || K < 1 || D < 1 || D > W || (W % D) != 0) begin : g_bad_cfg
        $error("mul_iter_hs: W must be >= 2, K >= 1 and D must divide W");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            neg_q, neg_d;
    logic [K-1:0]    key_q, key_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]   o_q, o_d;
    logic [K-1:0]    okey_q, okey_d;
    logic            oval_q, oval_d;
`ifdef MUL_ACC_EN
    logic [W2-1:0]   ic_q, ic_d;
`endif

    logic            accept;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic            neg_in;
    logic [W2-1:0]   pp;
    logic [W2-1:0]   pp_sh;
    logic [31:0]     sh;
    logic [W2-1:0]   acc_sgn;
    logic [W2-1:0]   res;
    logic            last;

    // A new operation may enter when idle, or when the held result leaves.
    assign irdy   = ~srst & ((state_q == IDLE) |
                             ((state_q == DONE) & ordy));
    assign accept = ival & irdy;

    assign o    = o_q;
    assign okey = okey_q;
    assign oval = oval_q;

    // Operand conditioning: signed operands become magnitudes plus a sign.
    always_comb begin
        a_mag  = ia;
        b_mag  = ib;
        neg_in = 1'b0;
        if (isgn) begin
            if (ia[W-1]) a_mag = ~ia + W'(1);
            if (ib[W-1]) b_mag = ~ib + W'(1);
            neg_in = ia[W-1] ^ ib[W-1];
        end
    end

    // Digit partial product, its weight, and the final sign/addend fixup.
    always_comb begin
        pp      = W2'(a_q) * W2'(b_q[D-1:0]);
        sh      = 32'(cnt_q) * 32'(D);
        pp_sh   = pp << sh;
        last    = (cnt_q == CW'(ND - 1));
        acc_sgn = neg_q ? (~acc_q + W2'(1)) : acc_q;
`ifdef MUL_ACC_EN
        res     = acc_sgn + ic_q;
`else
        res     = acc_sgn;
`endif
    end

    // Next-state and datapath update for the four-state sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        key_d   = key_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        okey_d  = okey_q;
        oval_d  = oval_q;
`ifdef MUL_ACC_EN
        ic_d    = ic_q;
`endif
        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            BUSY: begin
                acc_d = acc_q + pp_sh;
                b_d   = b_q >> D;
                cnt_d = cnt_q + CW'(1);
                if (last) state_d = FIX;
            end
            FIX: begin
                o_d     = res;
                okey_d  = key_q;
                oval_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (ordy) begin
                    oval_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Capture overrides the above; only reachable from IDLE or DONE.
        if (accept) begin
            a_d     = a_mag;
            b_d     = b_mag;
            neg_d   = neg_in;
            key_d   = ikey;
            acc_d   = '0;
            cnt_d   = '0;
`ifdef MUL_ACC_EN
            ic_d    = ic;
`endif
            state_d = BUSY;
        end
    end

    // State and datapath registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            key_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            o_q     <= '0;
            okey_q  <= '0;
            oval_q  <= 1'b0;
`ifdef MUL_ACC_EN
            ic_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            key_q   <= key_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            okey_q  <= okey_d;
            oval_q  <= oval_d;
`ifdef MUL_ACC_EN
            ic_q    <= ic_d;
`endif
        end
    end

endmodule
